uart_map_bridge: RTL and testbench

Byte-level bridge between the UART core and the LeNet controller. On receive it packs 36 consecutive UART bytes into one 288-bit feature-map row and hands it to the controller with a single-cycle valid pulse. It tracks rows per 144-row frame and discards stale partial rows after an idle timeout. On transmit it queues the controller's status and result bytes (0xFA init done, 0xFB map loaded, class result) and feeds them to the UART TX core under a start/busy handshake.

---
 rtl/lenet_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_map_bridge.sv | 144 ++++++++++++++
 tb/tb_uart_map_bridge.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet accelerator and its UART bridge.
package lenet_pkg;

    localparam int DATA_SIZE    = 8;
    localparam int MAP_WIDTH    = 288;
    localparam int WEIGHT_WIDTH = 208;
    localparam int MAP_ROWS     = 144;
    localparam int WEIGHT_ROWS  = 1040;

    // Status bytes reported back to the host over UART
    localparam logic [7:0] ST_INIT_DONE  = 8'hFA;
    localparam logic [7:0] ST_MAP_LOADED = 8'hFB;

    // TX handshake FSM encoding, kept as plain constants for legacy users
    typedef logic [1:0] txState_t;
    localparam txState_t TX_IDLE  = 2'd0;
    localparam txState_t TX_START = 2'd1;
    localparam txState_t TX_WAIT  = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; DEPTH must be a power of two >= 2.
// dout shows the head entry whenever the FIFO is not empty (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Extra pointer bit distinguishes full from empty when the indices match
    always_comb begin
        empty = (wrPtr == rdPtr);
        full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
        dout  = mem[rdPtr[AW-1:0]];
    end

    // Storage write; a push into a full FIFO is ignored
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr[AW-1:0]] <= din;
        end
    end

    // Pointer update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_map_bridge.sv
// UART <-> LeNet controller bridge: packs RX bytes into feature-map rows with
// an idle timeout, and queues controller bytes to the UART TX core.
module uart_map_bridge #(
    parameter int DATA_SIZE = 8,
    parameter int MAP_BYTES = 36,
    parameter int MAP_ROWS  = 144,
    parameter int TIMEOUT   = 100000,
    parameter int TXQ_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx_vld,
    input  logic [DATA_SIZE-1:0]           rx_byte,
    output logic                           map_ena,
    output logic [DATA_SIZE*MAP_BYTES-1:0] map_data,
    output logic                           frame_done,
    output logic [7:0]                     row_cnt,
    output logic                           rx_timeout,
    input  logic                           ctrl_ena,
    input  logic [DATA_SIZE-1:0]           ctrl_data,
    output logic                           tx_start,
    output logic [DATA_SIZE-1:0]           tx_byte,
    input  logic                           tx_busy,
    output logic                           tx_overflow
);

    import lenet_pkg::*;

    localparam int ROW_W  = DATA_SIZE * MAP_BYTES;
    localparam int BCNT_W = $clog2(MAP_BYTES);
    localparam int IDLE_W = $clog2(TIMEOUT);

    // Only the first 35 bytes are held; the last byte goes straight to map_data
    logic [ROW_W-DATA_SIZE-1:0] shiftReg;
    logic [BCNT_W-1:0]          byteCnt;
    logic [BCNT_W-1:0]          effCnt;
    logic [IDLE_W-1:0]          idleCnt;
    logic                       expire;
    logic                       rowDone;
    logic                       lastRow;

    // A byte arriving in the expiry cycle starts a fresh row, so the row
    // position is taken as zero whenever the timeout fires
    always_comb begin
        expire  = (byteCnt != '0) && (idleCnt == IDLE_W'(TIMEOUT - 1));
        effCnt  = expire ? '0 : byteCnt;
        rowDone = rx_vld && (effCnt == BCNT_W'(MAP_BYTES - 1));
        lastRow = (row_cnt == 8'(MAP_ROWS - 1));
    end

    // RX packing, row/frame counting and idle timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shiftReg   <= '0;
            byteCnt    <= '0;
            idleCnt    <= '0;
            map_ena    <= 1'b0;
            map_data   <= '0;
            frame_done <= 1'b0;
            row_cnt    <= '0;
            rx_timeout <= 1'b0;
        end else begin
            map_ena    <= rowDone;
            frame_done <= rowDone && lastRow;
            rx_timeout <= expire;

            if (rx_vld) begin
                shiftReg <= {shiftReg[ROW_W-2*DATA_SIZE-1:0], rx_byte};
                idleCnt  <= '0;
            end else if (expire || byteCnt == '0) begin
                idleCnt <= '0;
            end else begin
                idleCnt <= idleCnt + 1'b1;
            end

            if (rowDone) begin
                byteCnt  <= '0;
                map_data <= {shiftReg, rx_byte};
                row_cnt  <= lastRow ? '0 : row_cnt + 1'b1;
            end else if (rx_vld) begin
                byteCnt <= effCnt + 1'b1;
            end else if (expire) begin
                byteCnt <= '0;
            end
        end
    end

    txState_t             txState;
    logic                 fifoPop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [DATA_SIZE-1:0] fifoDout;

    sync_fifo #(
        .WIDTH(DATA_SIZE),
        .DEPTH(TXQ_DEPTH)
    ) txQueue (
        .clk  (clk),
        .rst_n(rst_n),
        .push (ctrl_ena),
        .din  (ctrl_data),
        .pop  (fifoPop),
        .dout (fifoDout),
        .full (fifoFull),
        .empty(fifoEmpty)
    );

    // Pop only from idle with the TX core free, so tx_start never meets busy
    always_comb begin
        fifoPop = (txState == TX_IDLE) && !fifoEmpty && !tx_busy;
    end

    // TX start/busy handshake and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txState     <= TX_IDLE;
            tx_start    <= 1'b0;
            tx_byte     <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (ctrl_ena && fifoFull) begin
                tx_overflow <= 1'b1;
            end
            case (txState)
                TX_IDLE: begin
                    if (fifoPop) begin
                        tx_byte  <= fifoDout;
                        tx_start <= 1'b1;
                        txState  <= TX_START;
                    end
                end
                TX_START: txState <= TX_WAIT;
                TX_WAIT: begin
                    if (!tx_busy) begin
                        txState <= TX_IDLE;
                    end
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_map_bridge.sv
// Directed bench for uart_map_bridge with RX/TX scoreboards and a TX core model.
module tb_uart_map_bridge;

    import lenet_pkg::*;

    localparam int TO   = 40;
    localparam int NB   = 36;
    localparam int ROWS = 144;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_vld = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic         map_ena;
    logic [287:0] map_data;
    logic         frame_done;
    logic [7:0]   row_cnt;
    logic         rx_timeout;
    logic         ctrl_ena = 1'b0;
    logic [7:0]   ctrl_data = '0;
    logic         tx_start;
    logic [7:0]   tx_byte;
    logic         tx_busy;
    logic         tx_overflow;

    always #5 clk = ~clk;

    uart_map_bridge #(
        .DATA_SIZE(8),
        .MAP_BYTES(NB),
        .MAP_ROWS (ROWS),
        .TIMEOUT  (TO),
        .TXQ_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_vld     (rx_vld),
        .rx_byte    (rx_byte),
        .map_ena    (map_ena),
        .map_data   (map_data),
        .frame_done (frame_done),
        .row_cnt    (row_cnt),
        .rx_timeout (rx_timeout),
        .ctrl_ena   (ctrl_ena),
        .ctrl_data  (ctrl_data),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .tx_overflow(tx_overflow)
    );

    typedef struct {
        logic [287:0] data;
        logic         frame;
        logic [7:0]   rows;
        int           cyc;
    } rxExp_t;

    rxExp_t       rxQ[$];
    logic [7:0]   txQ[$];
    int           startCyc[$];
    int           vecs = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           toCnt = 0;
    int           mapCnt = 0;
    int           frameCnt = 0;
    int           busyCnt = 0;
    logic         forceBusy = 1'b0;
    logic [287:0] modelShift = '0;
    int           modelCnt = 0;
    int           expRow = 0;
    int           c0;

    assign tx_busy = forceBusy || (busyCnt != 0);

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RX scoreboard: every row pulse must match the oldest expected row
    always @(negedge clk) begin
        if (map_ena) begin
            mapCnt++;
            if (frame_done) frameCnt++;
            if (rxQ.size() == 0) begin
                chk("map_ena unexpected", 1, 0);
            end else begin
                rxExp_t e;
                e = rxQ.pop_front();
                chk("map_data", map_data, e.data);
                chk("frame_done", frame_done, e.frame);
                chk("row_cnt", row_cnt, e.rows);
                chk("map_ena cycle", cyc, e.cyc);
            end
        end else if (frame_done) begin
            chk("frame_done without map_ena", 1, 0);
        end
        if (rx_timeout) toCnt++;
    end

    // TX core model: busy for 10 cycles after each start
    always @(negedge clk) begin
        if (tx_start) begin
            chk("tx_start while busy", tx_busy, 0);
            startCyc.push_back(cyc);
            if (txQ.size() == 0) chk("tx_start unexpected", 1, 0);
            else chk("tx_byte", tx_byte, txQ.pop_front());
            busyCnt = 10;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_vld   = 1'b1;
        rx_byte  = b;
        ctrl_ena = 1'b0;
        modelShift = {modelShift[279:0], b};
        modelCnt++;
        if (modelCnt == NB) begin
            rxExp_t e;
            e.data  = modelShift;
            e.frame = (expRow == ROWS - 1);
            expRow  = e.frame ? 0 : expRow + 1;
            e.rows  = 8'(expRow);
            e.cyc   = cyc + 1;
            rxQ.push_back(e);
            modelCnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_vld   = 1'b0;
            ctrl_ena = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #1;
        ctrl_ena  = 1'b1;
        ctrl_data = b;
        rx_vld    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rxQ.size() != 0 || txQ.size() != 0 || busyCnt != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain pending items", rxQ.size() + txQ.size(), 0);
        idle(2);
    endtask

    task automatic checkResetOutputs();
        chk("rst map_ena", map_ena, 0);
        chk("rst map_data", map_data, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst row_cnt", row_cnt, 0);
        chk("rst rx_timeout", rx_timeout, 0);
        chk("rst tx_start", tx_start, 0);
        chk("rst tx_byte", tx_byte, 0);
        chk("rst tx_overflow", tx_overflow, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rx_vld   = 1'b0;
        ctrl_ena = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n    = 1'b1;
        modelCnt = 0;
        expRow   = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [287:0] snap;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n = 1'b1;

        // one row, back-to-back bytes 0x00..0x23
        for (int i = 0; i < NB; i++) sendByte(8'(i));
        idle(1);
        drain();
        snap = map_data;
        chk("row1 first byte", snap[287:280], 8'h00);
        chk("row1 last byte", snap[7:0], 8'h23);
        chk("row1 row_cnt", row_cnt, 1);
        chk("row1 pulse count", mapCnt, 1);

        // full frame from a clean row count
        doReset();
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < NB; i++) sendByte(8'(r * 7 + i));
        idle(1);
        drain();
        chk("frame row_cnt wrap", row_cnt, 0);
        chk("frame_done count", frameCnt, 1);
        chk("frame pulse count", mapCnt, 1 + ROWS);

        // partial row dropped after a full idle timeout
        for (int i = 0; i < 10; i++) sendByte(8'(8'h40 + i));
        idle(TO);
        modelCnt = 0;
        for (int i = 0; i < NB; i++) sendByte(8'(8'h80 + i));
        idle(1);
        drain();
        snap = map_data;
        chk("timeout pulses", toCnt, 1);
        chk("after timeout first byte", snap[287:280], 8'h80);
        chk("after timeout row_cnt", row_cnt, 1);

        // byte arriving in the expiry cycle starts a new row
        for (int i = 0; i < 10; i++) sendByte(8'(8'h50 + i));
        idle(TO - 1);
        modelCnt = 0;
        for (int i = 0; i < NB; i++) sendByte(8'(8'hC0 + i));
        idle(1);
        drain();
        chk("expiry-cycle timeout pulses", toCnt, 2);
        chk("expiry-cycle row_cnt", row_cnt, 2);

        // one cycle short of timeout keeps the partial row
        for (int i = 0; i < 10; i++) sendByte(8'(8'h60 + i));
        idle(TO - 2);
        for (int i = 0; i < NB - 10; i++) sendByte(8'(8'h6A + i));
        idle(1);
        drain();
        chk("no timeout pulses", toCnt, 2);
        chk("no timeout row_cnt", row_cnt, 3);

        // status/result bytes through the TX handshake
        startCyc.delete();
        push(ST_INIT_DONE);
        c0 = cyc;
        txQ.push_back(ST_INIT_DONE);
        push(ST_MAP_LOADED);
        txQ.push_back(ST_MAP_LOADED);
        push(8'h07);
        txQ.push_back(8'h07);
        idle(1);
        drain();
        chk("tx start count", startCyc.size(), 3);
        chk("tx first latency", startCyc[0], c0 + 2);
        chk("tx no overflow", tx_overflow, 0);

        // overflow while the TX core is held busy
        forceBusy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
            if (i <= 4) txQ.push_back(8'(i));
        end
        idle(2);
        chk("overflow set", tx_overflow, 1);
        chk("no start while busy", startCyc.size(), 3);
        forceBusy = 1'b0;
        drain();
        chk("overflow sticky", tx_overflow, 1);
        chk("overflow start count", startCyc.size(), 7);

        // reset in the middle of a row
        for (int i = 0; i < 20; i++) sendByte(8'(8'hE0 + i));
        doReset();
        for (int i = 0; i < NB; i++) sendByte(8'(8'h10 + i));
        idle(1);
        drain();
        chk("post-reset row_cnt", row_cnt, 1);
        chk("total map_ena", mapCnt, ROWS + 5);
        chk("total timeouts", toCnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
